// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM ramp controller: FSM encoding, duty width,
// and the clamp/ramp arithmetic used by the top level.
package pwm_pkg;

  localparam int unsigned DUTY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] limit);
    return (duty > limit) ? limit : duty;
  endfunction

  // Moves cur one step toward tgt, landing exactly on tgt instead of overshooting.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt,
                                                  input logic [DUTY_W-1:0] step);
    if (cur < tgt)
      return ((tgt - cur) <= step) ? tgt : cur + step;
    else
      return ((cur - tgt) <= step) ? tgt : cur - step;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Period counter and duty comparator: counts 0..PERIOD-1, flags the last count
// (boundary) and the first count, and compares the count against the applied duty.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DUTY_W-1:0] duty,
  output logic              below_duty,
  output logic              boundary,
  output logic              at_zero
);

  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

  logic [DUTY_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || boundary)
      cnt <= '0;
    else
      cnt <= cnt + DUTY_W'(1);
  end

  assign boundary   = (cnt == LAST);
  assign at_zero    = (cnt == '0);
  assign below_duty = (cnt < duty);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with soft ramping of the duty toward a handshaked target; the duty
// only changes at period boundaries so each period is generated with a single duty.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = 100,
  parameter int unsigned STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              cfg_ready,
  output logic              signal,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              period_start,
  output logic              ramp_done
);

  localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] STEP_D   = DUTY_W'(STEP);

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] cfg_clamped;
  logic [DUTY_W-1:0] target_eff;
  logic [DUTY_W-1:0] duty_next;
  logic              handshake;
  logic              clear;
  logic              below_duty;
  logic              boundary;
  logic              at_zero;

  assign cfg_ready   = (state != ST_RAMP);
  assign handshake   = cfg_valid && cfg_ready;
  assign cfg_clamped = clamp_duty(cfg_duty, PERIOD_D);
  assign target_eff  = handshake ? cfg_clamped : target;
  assign duty_next   = ramp_step(duty_cur, target, STEP_D);

  // Counter is held at 0 in idle and zeroed on the same edge that drops to idle.
  assign clear = (state == ST_IDLE) || !enable;

  pwm_core #(
    .PERIOD(PERIOD)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .duty       (duty_cur),
    .below_duty (below_duty),
    .boundary   (boundary),
    .at_zero    (at_zero)
  );

  assign signal       = (state != ST_IDLE) && below_duty;
  assign period_start = (state != ST_IDLE) && at_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      duty_cur  <= '0;
      target    <= '0;
      ramp_done <= 1'b0;
    end else begin
      ramp_done <= 1'b0;
      if (handshake)
        target <= cfg_clamped;
      case (state)
        ST_IDLE: begin
          duty_cur <= '0;
          if (enable)
            state <= (target_eff != '0) ? ST_RAMP : ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state    <= ST_IDLE;
            duty_cur <= '0;
          end else if (handshake && (cfg_clamped != duty_cur)) begin
            // A handshake on a boundary leaves that boundary's duty untouched;
            // the first ramp step happens at the following boundary.
            state <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (!enable) begin
            state    <= ST_IDLE;
            duty_cur <= '0;
          end else if (boundary) begin
            duty_cur <= duty_next;
            if (duty_next == target) begin
              state     <= ST_RUN;
              ramp_done <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          duty_cur <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scenario bench for pwm_ramp_ctrl (PERIOD=10, STEP=2): expected per-period duty and
// cfg_ready are queued with the stimulus and checked at each period_start.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

  localparam int unsigned PERIOD = 10;
  localparam int unsigned STEP   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_duty;
  logic       cfg_ready;
  logic       signal;
  logic [7:0] duty_cur;
  logic       period_start;
  logic       ramp_done;

  typedef struct {
    int duty;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   done_count = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .PERIOD(PERIOD),
    .STEP  (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_duty    (cfg_duty),
    .cfg_ready   (cfg_ready),
    .signal      (signal),
    .duty_cur    (duty_cur),
    .period_start(period_start),
    .ramp_done   (ramp_done)
  );

  // Scoreboard: each period start consumes one queued expectation.
  always @(negedge clk) begin : sb
    exp_t e;
    if (ramp_done === 1'b1) done_count++;
    if (period_start === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (duty_cur !== 8'(e.duty)) begin
        errors++;
        $display("FAIL period_duty: got %0d, expected %0d at %0t", duty_cur, e.duty, $time);
      end
      checks++;
      if (cfg_ready !== e.ready) begin
        errors++;
        $display("FAIL period_ready: got %b, expected %b at %0t", cfg_ready, e.ready, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_duty  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_ps(input string name);
    for (int i = 0; i < 3 * PERIOD && period_start !== 1'b1; i++) tick();
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_period_start: got %b, expected 1", name, period_start);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_duty = '0;
    repeat (3) tick();
    checks++; if (signal !== 1'b0) begin errors++; $display("FAIL reset_signal: got %b, expected 0", signal); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b, expected 0", period_start); end
    checks++; if (ramp_done !== 1'b0) begin errors++; $display("FAIL reset_ramp_done: got %b, expected 0", ramp_done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_ready); end
    checks++; if (duty_cur !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d, expected 0", duty_cur); end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL idle_period_start: got %b, expected 0", period_start); end
  endtask

  task automatic test_soft_start();
    int d0;
    int hi;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL soft_ready: got %b, expected 1", cfg_ready); end
    offer(8'd6);
    checks++; if (duty_cur !== 8'd0 || period_start !== 1'b0) begin errors++; $display("FAIL soft_idle_cfg: duty %0d ps %b, expected 0 0", duty_cur, period_start); end
    d0 = done_count;
    exp_q.push_back('{0, 1'b0});
    exp_q.push_back('{2, 1'b0});
    exp_q.push_back('{4, 1'b0});
    exp_q.push_back('{6, 1'b1});
    enable = 1'b1;
    tick();
    wait_drain("soft", 5 * PERIOD);
    wait_ps("soft");
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (signal === 1'b1) hi++;
      tick();
    end
    checks++; if (hi != 6) begin errors++; $display("FAIL soft_high_cycles: got %0d, expected 6", hi); end
    checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL soft_ramp_done: got %0d pulses, expected 1", done_count - d0); end
  endtask

  task automatic test_clamp();
    int d0;
    int hi;
    d0 = done_count;
    offer(8'd15);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL clamp_ready_ramp: got %b, expected 0", cfg_ready); end
    exp_q.push_back('{8, 1'b0});
    exp_q.push_back('{10, 1'b1});
    wait_drain("clamp", 4 * PERIOD);
    wait_ps("clamp");
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (signal === 1'b1) hi++;
      tick();
    end
    checks++; if (hi != 10) begin errors++; $display("FAIL clamp_high_cycles: got %0d, expected 10", hi); end
    checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL clamp_ramp_done: got %0d pulses, expected 1", done_count - d0); end
  endtask

  task automatic test_ramp_down();
    offer(8'd7);
    exp_q.push_back('{8, 1'b0});
    exp_q.push_back('{7, 1'b1});
    wait_drain("to7", 4 * PERIOD);
    checks++; if (duty_cur !== 8'd7) begin errors++; $display("FAIL down_start_duty: got %0d, expected 7", duty_cur); end
    offer(8'd2);
    exp_q.push_back('{5, 1'b0});
    exp_q.push_back('{3, 1'b0});
    exp_q.push_back('{2, 1'b1});
    wait_drain("down", 5 * PERIOD);
    checks++; if (cfg_ready !== 1'b1 || duty_cur !== 8'd2) begin errors++; $display("FAIL down_end: ready %b duty %0d, expected 1 2", cfg_ready, duty_cur); end
  endtask

  task automatic test_abort();
    int  d0;
    bit  seen;
    offer(8'd8);
    exp_q.push_back('{4, 1'b0});
    wait_drain("abort_setup", 3 * PERIOD);
    checks++; if (duty_cur !== 8'd4 || signal !== 1'b1) begin errors++; $display("FAIL abort_pre: duty %0d sig %b, expected 4 1", duty_cur, signal); end
    d0 = done_count;
    enable = 1'b0;
    tick();
    checks++; if (signal !== 1'b0) begin errors++; $display("FAIL abort_signal: got %b, expected 0", signal); end
    checks++; if (duty_cur !== 8'd0) begin errors++; $display("FAIL abort_duty: got %0d, expected 0", duty_cur); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, expected 1", cfg_ready); end
    seen = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (signal !== 1'b0 || period_start !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_idle_quiet: got activity, expected none"); end
    checks++; if (done_count != d0) begin errors++; $display("FAIL abort_ramp_done: got %0d pulses, expected 0", done_count - d0); end
  endtask

  task automatic test_collision();
    offer(8'd4);
    checks++; if (duty_cur !== 8'd0 || period_start !== 1'b0) begin errors++; $display("FAIL coll_idle_cfg: duty %0d ps %b, expected 0 0", duty_cur, period_start); end
    exp_q.push_back('{0, 1'b0});
    exp_q.push_back('{2, 1'b0});
    exp_q.push_back('{4, 1'b1});
    enable = 1'b1;
    tick();
    wait_drain("coll_setup", 4 * PERIOD);
    repeat (PERIOD - 2) tick();
    checks++; if (signal !== 1'b0 || period_start !== 1'b0) begin errors++; $display("FAIL coll_pre: sig %b ps %b, expected 0 0", signal, period_start); end
    exp_q.push_back('{4, 1'b0});
    exp_q.push_back('{6, 1'b0});
    exp_q.push_back('{8, 1'b1});
    offer(8'd8);
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL coll_on_boundary: ps %b, expected 1", period_start); end
    wait_drain("coll", 5 * PERIOD);
  endtask

  task automatic test_async_reset();
    int d0;
    bit seen;
    offer(8'd2);
    exp_q.push_back('{6, 1'b0});
    wait_drain("arst_setup", 3 * PERIOD);
    tick();
    checks++; if (signal !== 1'b1) begin errors++; $display("FAIL arst_pre_signal: got %b, expected 1", signal); end
    d0 = done_count;
    #2 rst = 1'b1;
    #1;
    checks++; if (signal !== 1'b0) begin errors++; $display("FAIL arst_signal: got %b, expected 0", signal); end
    checks++; if (duty_cur !== 8'd0) begin errors++; $display("FAIL arst_duty: got %0d, expected 0", duty_cur); end
    checks++; if (period_start !== 1'b0 || ramp_done !== 1'b0) begin errors++; $display("FAIL arst_pulses: ps %b rd %b, expected 0 0", period_start, ramp_done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b, expected 1", cfg_ready); end
    repeat (2) tick();
    @(negedge clk) rst = 1'b0;
    tick();
    checks++; if (period_start !== 1'b1 || duty_cur !== 8'd0) begin errors++; $display("FAIL arst_rerun: ps %b duty %0d, expected 1 0", period_start, duty_cur); end
    seen = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (signal !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL arst_zero_duty: signal went high, expected constant 0"); end
    checks++; if (done_count != d0) begin errors++; $display("FAIL arst_ramp_done: got %0d pulses, expected 0", done_count - d0); end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_clamp();
    test_ramp_down();
    test_abort();
    test_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
